// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and default parameters for the SPI slave
package spi_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_TX_DEFAULT  = 0;

endpackage

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - flop-chain synchronizer with rise/fall pulses on the synchronized level
module spi_slave_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI slave with TX holding and RX valid/ack handshakes
// SPI_SLAVE_OVERRUN_EN adds a sticky overrun flag for frames overwriting unread rx_data.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
  parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = DATA_WIDTH'(SPI_TX_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_next;
  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0]  mosi_chain;
  logic                    mosi_s;
  logic [DATA_WIDTH-1:0]   tx_shift, rx_shift, hold_reg;
  logic                    hold_full;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    active, shift_load, frame_done;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  assign mosi_s = mosi_chain[SYNC_STAGES-1];
  assign active = (state == ACTIVE);

  // Shifter loads at frame start and at every word boundary while cs_n stays low.
  assign shift_load = (!active && cs_fall) ||
                      (active && !cs_rise && sclk_fall && bit_cnt == '0);
  assign frame_done = active && !cs_rise && sclk_rise && bit_cnt == LAST_BIT;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (cs_fall) state_next = ACTIVE;
      ACTIVE: if (cs_rise) state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_chain <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};

      if (shift_load) begin
        tx_shift  <= hold_full ? hold_reg : TX_DEFAULT;
        hold_full <= 1'b0;
      end else if (active && sclk_fall) begin
        tx_shift <= tx_shift << 1;
      end

      // Sees the pre-load hold_full, so a same-cycle write lands for the next word.
      if (tx_load && !hold_full) begin
        hold_reg  <= tx_data;
        hold_full <= 1'b1;
      end

      if (!active && cs_fall) begin
        bit_cnt <= '0;
      end else if (active && cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (active && sclk_rise) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        bit_cnt  <= frame_done ? '0 : bit_cnt + CNT_W'(1);
      end

      if (frame_done) begin
        rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                               overrun <= 1'b0;
    else if (frame_done && rx_valid && !rx_ack) overrun <= 1'b1;
    else if (rx_ack)                          overrun <= 1'b0;
  end
`endif

  assign miso     = active & tx_shift[DATA_WIDTH-1];
  assign busy     = active;
  assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized bench for spi_slave against a word-level reference model
module tb_spi_slave;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_load = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int failures = 0;

  // Word-level model: holding register, the word the master will see next, last RX word.
  bit         m_full = 1'b0;
  logic [7:0] m_hold = 8'h00;
  logic [7:0] m_next = 8'h00;
  logic [7:0] m_rx = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr = 1'b0;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic take_word(output logic [7:0] w);
    w = m_full ? m_hold : 8'h00;
    m_full = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rx_valid"}, rx_valid, m_valid);
    check({tag, "_rx_data"}, rx_data, m_rx);
    check({tag, "_tx_ready"}, tx_ready, !m_full);
`ifdef SPI_SLAVE_OVERRUN_EN
    check({tag, "_overrun"}, overrun, m_ovr);
`endif
  endtask

  task automatic load_tx(input logic [7:0] d);
    check("tx_ready_pre", tx_ready, !m_full);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    if (!m_full) begin
      m_hold = d;
      m_full = 1'b1;
    end
    check("tx_ready_post", tx_ready, !m_full);
  endtask

  task automatic ack_rx();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    check_outputs("ack");
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    wait_clk(8);
    take_word(m_next);
    check("busy_start", busy, 1);
    check("tx_ready_start", tx_ready, !m_full);
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    wait_clk(6);
    check("busy_end", busy, 0);
    check("miso_idle", miso, 0);
  endtask

  task automatic xfer_bits(input logic [7:0] mo, input int nbits, input int load_at,
                           input logic [7:0] ld);
    logic [7:0] mi;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      wait_clk(H);
      sclk = 1'b1;
      mi[7-i] = miso;
      if (i == load_at) load_tx(ld);
      wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
    if (nbits == 8) begin
      check("miso_word", mi, m_next);
      take_word(m_next);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_rx = mo;
    end
    check_outputs("xfer");
  endtask

  initial begin
    wait_clk(3);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check_outputs("rst");
    rst_n = 1'b1;
    wait_clk(4);

    // 1: preloaded response
    load_tx(8'h3C);
    frame_start();
    xfer_bits(8'hA5, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // 2: nothing loaded, default word returned
    frame_start();
    xfer_bits(8'h81, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // 3: back-to-back words with a mid-frame load
    load_tx(8'h55);
    frame_start();
    xfer_bits(8'h12, 8, 3, 8'hAA);
    ack_rx();
    xfer_bits(8'h34, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // 4: aborted partial frame, then a clean one
    frame_start();
    xfer_bits(8'hE7, 3, -1, 8'h00);
    frame_end();
    check("abort_rx_valid", rx_valid, 0);
    frame_start();
    xfer_bits(8'hF0, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // 5: overwrite without ack
    frame_start();
    xfer_bits(8'h11, 8, -1, 8'h00);
    frame_end();
    frame_start();
    xfer_bits(8'h22, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // 6: reset mid-frame
    load_tx(8'h99);
    frame_start();
    xfer_bits(8'hC3, 4, -1, 8'h00);
    rst_n = 1'b0;
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(1);
    m_full = 1'b0; m_valid = 1'b0; m_rx = 8'h00; m_ovr = 1'b0;
    check("rst6_busy", busy, 0);
    check("rst6_miso", miso, 0);
    check_outputs("rst6");
    rst_n = 1'b1;
    wait_clk(4);
    frame_start();
    xfer_bits(8'h5A, 8, -1, 8'h00);
    frame_end();
    ack_rx();

    // Randomized frames
    for (int r = 0; r < 24; r++) begin
      int nb;
      if ($urandom_range(1, 0) == 1) load_tx(8'($urandom));
      frame_start();
      nb = $urandom_range(2, 1);
      for (int b = 0; b < nb; b++) begin
        int la;
        la = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
        xfer_bits(8'($urandom), 8, la, 8'($urandom));
        if ($urandom_range(1, 0) == 1) ack_rx();
      end
      frame_end();
      if (m_valid && $urandom_range(1, 0) == 1) ack_rx();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) for the SPI master block; the receiving end of the same 4-wire link.
- Runs on the system clock and oversamples the external sclk, cs_n and mosi through synchronizers.
- Mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
- Exposes a parallel TX holding register with a ready/load handshake and an RX register with a valid/ack handshake. Used as the bench's responder model and as a synthesizable peripheral.

Parameters:
- DATA_WIDTH, 8: frame length in bits.
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi (minimum 2).
- TX_DEFAULT, 0: word shifted out when no TX data is loaded at frame start.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock from master (asynchronous to clk).
- cs_n  in  1  chip select from master, active-low.
- mosi  in  1  master-out serial data.
- miso  out  1  slave-out serial data.
- tx_data  in  DATA_WIDTH  word to send in the next frame.
- tx_load  in  1  write strobe for tx_data.
- tx_ready  out  1  TX holding register empty.
- rx_data  out  DATA_WIDTH  last complete received frame.
- rx_valid  out  1  rx_data holds unread data.
- rx_ack  in  1  consumer has taken rx_data.
- busy  out  1  frame in progress.

Behaviour:
- Single clock domain clk. Reset is synchronous, active-low, on rst_n.
- Reset values:
  - miso=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
  - Shifters, bit counter and holding register cleared.
  - Synchronizers preset: cs_n chain=1, sclk chain=0, mosi chain=0.
- Reset takes effect regardless of an in-progress frame; the partial frame is discarded and there is no rx_valid.
- Edge detection: rise and fall on synchronized sclk and cs_n, each a 1-cycle pulse.
- Timing requirement on the master:
  - Each sclk level is held at least 2 clk cycles.
  - The first sclk rising edge comes at least SYNC_STAGES+2 clk after the cs_n falling edge.
  - With SYNC_STAGES=2, master CLK_DIV>=4 satisfies this.
- State machine, states IDLE and ACTIVE:
  - IDLE → ACTIVE on synchronized cs_n fall. In the same cycle: tx shifter ← holding register (or TX_DEFAULT if empty), holding register marked empty, bit_cnt=0. miso shows MSB from the next cycle.
  - ACTIVE, on sclk rise: rx shifter ← {rx_shift[DATA_WIDTH-2:0], mosi_s}, bit_cnt+1. When bit_cnt reaches DATA_WIDTH: rx_data ← completed word, rx_valid=1 next cycle, bit_cnt=0.
  - ACTIVE, on sclk fall: if bit_cnt≠0, shift tx left and drive the next bit. If bit_cnt==0 (frame boundary, cs_n still low), reload the tx shifter from the holding register or TX_DEFAULT; this gives back-to-back frames.
  - ACTIVE → IDLE on cs_n rise: a partial frame is dropped without rx_valid, bit_cnt=0, miso=0.
- busy=1 exactly while in ACTIVE. miso=0 in IDLE (no tristate).
- TX handshake:
  - tx_load with tx_ready=1 captures tx_data; tx_ready=0 next cycle.
  - tx_load with tx_ready=0 is ignored; the holding register is not overwritten.
  - tx_ready returns to 1 the cycle after the shifter takes the word.
  - tx_load in the same cycle as a shifter load: the old (empty) state is used for the load, and the new word is captured for the following frame.
- RX handshake:
  - rx_valid stays high until rx_ack. rx_ack with rx_valid=1 clears it next cycle.
  - rx_data is stable while rx_valid=1, except on overwrite.
  - A frame completing while rx_valid=1 overwrites rx_data, and rx_valid stays 1.
  - rx_ack in the same cycle as a frame completion: new data wins and rx_valid stays 1.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined: adds output port overrun (1 bit, reset 0). It is sticky-set when a frame completes while rx_valid=1 and rx_ack=0, and it clears on rx_ack unless a set occurs in the same cycle (set wins).
- Undefined: no port, no logic; overwrite is silent.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum typedef {IDLE, ACTIVE};
  - default constants for DATA_WIDTH, SYNC_STAGES and TX_DEFAULT.
- Sub-module spi_slave_sync: a SYNC_STAGES flop chain with reset value parameter plus rise/fall pulse outputs. Instantiated for sclk and cs_n; mosi uses the chain only.

Test Plan:
1. Preload 0x3C, master sends 0xA5 → rx_data=0xA5 with rx_valid=1; master rx_data=0x3C; tx_ready back to 1 after the frame starts.
2. No tx_load, master sends 0x81 → master receives 0x00 (TX_DEFAULT); rx_data=0x81.
3. cs_n held low for 16 bits, mosi 0x12 then 0x34; tx 0x55 preloaded and 0xAA loaded mid-frame → rx_valid pulses after each byte with 0x12 then 0x34; master gets 0x55 then 0xAA.
4. cs_n rises after 3 bits → no rx_valid, busy=0; next full frame 0xF0 is received correctly.
5. Two frames (0x11, 0x22) without rx_ack → rx_data=0x22 and rx_valid=1; with SPI_SLAVE_OVERRUN_EN, overrun=1, cleared by rx_ack.
6. rst_n low for one cycle mid-frame → all outputs at reset values next cycle; subsequent frame 0x5A is received cleanly.
